pauli_rom_streamer: RTL and testbench

- Parametrised successor to the single-port Pauli-string block-ROM controller.
- Streams a contiguous range of Pauli-string words for an N-qubit system out of an external block ROM, which has a fixed read latency.
- Supports a positive/negated bank select, wraps at the bank boundary, and uses valid/ready backpressure with a small credit-controlled buffer.
- Sits between the tomography control FSM (start/range/neg) and the measurement-basis datapath (dout stream).

---
 rtl/pauli_rom_streamer.sv | 165 ++++++++++++++++
 tb/tb_pauli_rom_streamer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pauli_rom_streamer.sv
// Streams a contiguous, bank-wrapped range of Pauli-string words out of an
// external fixed-latency block ROM. Reads are gated by a credit rule so the
// small output buffer can never overflow under valid/ready backpressure.
module pauli_rom_streamer #(
   parameter int unsigned N_QUBITS  = 3,
   parameter int unsigned ADDR_W    = 2 * N_QUBITS,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned ROM_LAT   = 1,
   parameter int unsigned BUF_DEPTH = ROM_LAT + 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   input  logic              neg,
   output logic              busy,
   output logic              done,
   output logic              rom_en,
   output logic [ADDR_W:0]   rom_addr,
   input  logic [DATA_W-1:0] rom_dout,
   output logic [DATA_W-1:0] dout,
   output logic [ADDR_W-1:0] dout_idx,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              last
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned BANK  = 1 << ADDR_W;
   localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]    rem_q, rem_d;
   logic                neg_q, neg_d;
   logic                issue;

   logic [ROM_LAT-1:0]  pv_q;
   logic [ROM_LAT-1:0]  plast_q;
   logic [ADDR_W-1:0]   pidx_q [ROM_LAT];

   logic [DATA_W-1:0]   bdat_q [BUF_DEPTH];
   logic [ADDR_W-1:0]   bidx_q [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] blast_q;
   logic [PTR_W-1:0]    rd_q, wr_q;
   logic [OCC_W-1:0]    occ_q, infl, outst;
   logic                push, pop, head_last, credit_ok;
   logic [CNT_W-1:0]    count_sat;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit accounting: reads in flight plus buffered words must stay below depth
   always_comb begin
      infl = '0;
      for (int k = 0; k < ROM_LAT; k++) begin
         infl = infl + OCC_W'(pv_q[k]);
      end
      outst     = infl + occ_q;
      credit_ok = outst < OCC_W'(BUF_DEPTH);
   end

   assign count_sat = (count > CNT_W'(BANK)) ? CNT_W'(BANK) : count;
   assign push      = pv_q[ROM_LAT-1];
   assign pop       = (occ_q != '0) && dout_ready;
   assign head_last = blast_q[rd_q];

   // Next-state and read-issue logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      neg_d   = neg_q;
      issue   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ptr_d   = base_addr;
               neg_d   = neg;
               rem_d   = count_sat;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // An empty range is resolved here, once the latched count is visible
            if (rem_q == '0) begin
               state_d = S_FIN;
            end else if (credit_ok) begin
               issue = 1'b1;
               ptr_d = ptr_q + ADDR_W'(1);
               rem_d = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pop && head_last) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state, in-flight valid tags and buffer pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         neg_q   <= 1'b0;
         pv_q    <= '0;
         occ_q   <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         neg_q   <= neg_d;
         pv_q[0] <= issue;
         for (int k = 1; k < ROM_LAT; k++) begin
            pv_q[k] <= pv_q[k-1];
         end
         if (push) wr_q <= ptr_inc(wr_q);
         if (pop)  rd_q <= ptr_inc(rd_q);
         occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);
      end
   end

   // Tag payload and buffer storage; validity is carried by the reset-cleared flops
   always_ff @(posedge clk) begin
      pidx_q[0]  <= ptr_q;
      plast_q[0] <= (rem_q == CNT_W'(1));
      for (int k = 1; k < ROM_LAT; k++) begin
         pidx_q[k]  <= pidx_q[k-1];
         plast_q[k] <= plast_q[k-1];
      end
      if (push) begin
         bdat_q[wr_q]  <= rom_dout;
         bidx_q[wr_q]  <= pidx_q[ROM_LAT-1];
         blast_q[wr_q] <= plast_q[ROM_LAT-1];
      end
   end

   // Head of buffer is forced to zero while empty so idle outputs are clean
   assign dout_valid = (occ_q != '0);
   assign dout       = dout_valid ? bdat_q[rd_q] : '0;
   assign dout_idx   = dout_valid ? bidx_q[rd_q] : '0;
   assign last       = dout_valid && head_last;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_FIN);
   assign rom_en     = issue;
   assign rom_addr   = {neg_q, ptr_q};

endmodule

// File: tb/tb_pauli_rom_streamer.sv
// Directed bench for pauli_rom_streamer: a ROM_LAT=1 and a ROM_LAT=2 instance,
// each with its own behavioural ROM; one is observed at a time through sel.
module tb_pauli_rom_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start1, start2;
   logic [5:0]  base_addr;
   logic [6:0]  count;
   logic        neg;
   logic        dout_ready;

   logic        busy1, done1, rom_en1, dout_valid1, last1;
   logic [6:0]  rom_addr1;
   logic [63:0] rom_dout1, dout1;
   logic [5:0]  dout_idx1;
   logic        busy2, done2, rom_en2, dout_valid2, last2;
   logic [6:0]  rom_addr2;
   logic [63:0] rom_dout2, dout2, rom_stage2;
   logic [5:0]  dout_idx2;

   bit          sel;
   logic        o_busy, o_done, o_rom_en, o_valid, o_last;
   logic [6:0]  o_rom_addr;
   logic [63:0] o_dout;
   logic [5:0]  o_idx;

   int n_checks = 0;
   int n_err    = 0;

   int          beat_idx[$];
   logic [63:0] beat_dat[$];
   bit          beat_last[$];
   int          beat_cyc[$];
   int          addr_q[$];
   int          done_cyc, done_pulses, credit_viol, stable_viol, valid_cnt;
   logic        busy_after;

   always #5 clk = ~clk;

   pauli_rom_streamer #(.N_QUBITS(3), .ROM_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .base_addr(base_addr), .count(count),
      .neg(neg), .busy(busy1), .done(done1), .rom_en(rom_en1), .rom_addr(rom_addr1),
      .rom_dout(rom_dout1), .dout(dout1), .dout_idx(dout_idx1), .dout_valid(dout_valid1),
      .dout_ready(dout_ready), .last(last1));

   pauli_rom_streamer #(.N_QUBITS(3), .ROM_LAT(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr), .count(count),
      .neg(neg), .busy(busy2), .done(done2), .rom_en(rom_en2), .rom_addr(rom_addr2),
      .rom_dout(rom_dout2), .dout(dout2), .dout_idx(dout_idx2), .dout_valid(dout_valid2),
      .dout_ready(dout_ready), .last(last2));

   function automatic logic [63:0] word(input logic [6:0] a);
      return {25'h1A5A5A5, a, 25'h0F0F0F0, ~a};
   endfunction

   // Behavioural ROMs with one and two cycles of read latency
   always @(posedge clk) begin
      if (rom_en1) rom_dout1 <= word(rom_addr1);
      if (rom_en2) rom_stage2 <= word(rom_addr2);
      rom_dout2 <= rom_stage2;
   end

   assign o_busy     = sel ? busy2       : busy1;
   assign o_done     = sel ? done2       : done1;
   assign o_rom_en   = sel ? rom_en2     : rom_en1;
   assign o_rom_addr = sel ? rom_addr2   : rom_addr1;
   assign o_dout     = sel ? dout2       : dout1;
   assign o_idx      = sel ? dout_idx2   : dout_idx1;
   assign o_valid    = sel ? dout_valid2 : dout_valid1;
   assign o_last     = sel ? last2       : last1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Launch one stream in the current cycle (cycle 0) and log it until the cycle after done
   task automatic run(input int b, input int c, input bit n, input bit bp,
                      input int budget, input int restart_at);
      bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int          issued = 0;
      int          popped = 0;
      int          bd;
      bit          prev_stall = 1'b0;
      logic [63:0] prev_dout = '0;
      logic [5:0]  prev_idx = '0;
      bd = sel ? 4 : 3;
      beat_idx.delete(); beat_dat.delete(); beat_last.delete(); beat_cyc.delete();
      addr_q.delete();
      done_cyc = -1; done_pulses = 0; credit_viol = 0; stable_viol = 0; valid_cnt = 0;
      busy_after = 1'bx;
      base_addr = 6'(b); count = 7'(c); neg = n; dout_ready = 1'b1;
      if (sel) start2 = 1'b1; else start1 = 1'b1;
      tick();
      for (int cyc = 1; cyc <= budget; cyc++) begin
         if (cyc > 1) tick();
         start1 = 1'b0; start2 = 1'b0;
         if (cyc == restart_at) begin
            base_addr = 6'd40;
            if (sel) start2 = 1'b1; else start1 = 1'b1;
         end
         dout_ready = bp ? pat[cyc % 4] : 1'b1;
         #1;
         if (o_rom_en) begin
            if (issued - popped >= bd) credit_viol++;
            addr_q.push_back(int'(o_rom_addr));
            issued++;
         end
         if (prev_stall && (!o_valid || o_dout !== prev_dout || o_idx !== prev_idx)) stable_viol++;
         if (o_valid) valid_cnt++;
         if (o_valid && dout_ready) begin
            beat_idx.push_back(int'(o_idx));
            beat_dat.push_back(o_dout);
            beat_last.push_back(o_last);
            beat_cyc.push_back(cyc);
            popped++;
         end
         prev_stall = o_valid && !dout_ready;
         prev_dout  = o_dout;
         prev_idx   = o_idx;
         if (o_done) begin
            done_pulses++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            busy_after = o_busy;
            break;
         end
      end
      start1 = 1'b0; start2 = 1'b0; dout_ready = 1'b1;
      chk("done_seen_in_budget", 64'(done_cyc >= 0), 64'd1);
   endtask

   task automatic chk_beats(input string tag, input int b, input int n_beats, input bit n);
      chk({tag, "_beats"}, 64'(beat_idx.size()), 64'(n_beats));
      for (int i = 0; i < beat_idx.size() && i < n_beats; i++) begin
         chk({tag, "_idx"},  64'(beat_idx[i]), 64'((b + i) % 64));
         chk({tag, "_data"}, beat_dat[i], word({n, 6'((b + i) % 64)}));
         chk({tag, "_last"}, 64'(beat_last[i]), 64'(i == n_beats - 1));
      end
   endtask

   initial begin
      int e_addr[4];
      int e_idx[4];
      rst = 1'b1; start1 = 1'b0; start2 = 1'b0; base_addr = '0; count = '0;
      neg = 1'b0; dout_ready = 1'b1; sel = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_busy",     64'(busy1), 64'd0);
      chk("rst_done",     64'(done1), 64'd0);
      chk("rst_rom_en",   64'(rom_en1), 64'd0);
      chk("rst_rom_addr", 64'(rom_addr1), 64'd0);
      chk("rst_dout",     dout1, 64'd0);
      chk("rst_idx",      64'(dout_idx1), 64'd0);
      chk("rst_valid",    64'(dout_valid1), 64'd0);
      chk("rst_last",     64'(last1), 64'd0);
      chk("rst_busy2",    64'(busy2), 64'd0);
      rst = 1'b0;
      tick();

      // Basic stream: base 5, count 4, positive bank
      run(5, 4, 1'b0, 1'b0, 20, -1);
      e_addr = '{5, 6, 7, 8};
      chk("basic_n_reads", 64'(addr_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < addr_q.size(); i++) chk("basic_rom_addr", 64'(addr_q[i]), 64'(e_addr[i]));
      chk_beats("basic", 5, 4, 1'b0);
      if (beat_cyc.size() == 4) begin
         chk("basic_first_valid_cyc", 64'(beat_cyc[0]), 64'd3);
         chk("basic_last_beat_cyc",   64'(beat_cyc[3]), 64'd6);
      end
      chk("basic_done_cyc",    64'(done_cyc), 64'd7);
      chk("basic_done_pulses", 64'(done_pulses), 64'd1);
      chk("basic_busy_after",  64'(busy_after), 64'd0);
      tick();

      // Wrap inside the negated bank
      run(62, 4, 1'b1, 1'b0, 20, -1);
      e_addr = '{126, 127, 64, 65};
      e_idx  = '{62, 63, 0, 1};
      chk("wrap_n_reads", 64'(addr_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < addr_q.size(); i++) chk("wrap_rom_addr", 64'(addr_q[i]), 64'(e_addr[i]));
      for (int i = 0; i < 4 && i < beat_idx.size(); i++) chk("wrap_idx", 64'(beat_idx[i]), 64'(e_idx[i]));
      chk_beats("wrap", 62, 4, 1'b1);
      tick();

      // Backpressure with ready pattern 1,0,0,1
      run(0, 8, 1'b0, 1'b1, 80, -1);
      chk_beats("bp", 0, 8, 1'b0);
      chk("bp_n_reads",    64'(addr_q.size()), 64'd8);
      chk("bp_credit",     64'(credit_viol), 64'd0);
      chk("bp_stable",     64'(stable_viol), 64'd0);
      chk("bp_done_pulse", 64'(done_pulses), 64'd1);
      tick();

      // Empty range
      run(9, 0, 1'b0, 1'b0, 20, -1);
      chk("zero_done_cyc",   64'(done_cyc), 64'd2);
      chk("zero_reads",      64'(addr_q.size()), 64'd0);
      chk("zero_valids",     64'(valid_cnt), 64'd0);
      chk("zero_busy_after", 64'(busy_after), 64'd0);
      tick();

      // Oversized count saturates to the bank depth
      run(10, 127, 1'b0, 1'b0, 120, -1);
      chk_beats("sat", 10, 64, 1'b0);
      chk("sat_done_cyc", 64'(done_cyc), 64'd67);
      tick();

      // Start during RUN is ignored
      run(30, 6, 1'b0, 1'b0, 30, 2);
      chk_beats("restart", 30, 6, 1'b0);
      chk("restart_done_cyc",   64'(done_cyc), 64'd9);
      chk("restart_busy_after", 64'(busy_after), 64'd0);
      tick();

      // Reset after the third beat aborts the stream
      base_addr = 6'd20; count = 7'd10; neg = 1'b0; start1 = 1'b1;
      tick(); start1 = 1'b0;          // cycle 1
      repeat (4) tick();              // cycle 5
      chk("abort_third_valid", 64'(dout_valid1), 64'd1);
      chk("abort_third_idx",   64'(dout_idx1), 64'd22);
      tick(); rst = 1'b1;             // cycle 6
      tick(); rst = 1'b0;             // cycle 7
      chk("abort_busy",     64'(busy1), 64'd0);
      chk("abort_done",     64'(done1), 64'd0);
      chk("abort_rom_en",   64'(rom_en1), 64'd0);
      chk("abort_rom_addr", 64'(rom_addr1), 64'd0);
      chk("abort_dout",     dout1, 64'd0);
      chk("abort_idx",      64'(dout_idx1), 64'd0);
      chk("abort_valid",    64'(dout_valid1), 64'd0);
      chk("abort_last",     64'(last1), 64'd0);
      tick();                         // cycle 8: late ROM word must not appear
      chk("abort_late_valid", 64'(dout_valid1), 64'd0);
      chk("abort_late_done",  64'(done1), 64'd0);
      run(3, 2, 1'b0, 1'b0, 20, -1);
      chk_beats("post_abort", 3, 2, 1'b0);
      chk("post_abort_done_cyc", 64'(done_cyc), 64'd5);
      tick();

      // Two-cycle ROM latency instance
      sel = 1'b1;
      run(0, 16, 1'b0, 1'b0, 60, -1);
      chk_beats("lat2", 0, 16, 1'b0);
      for (int i = 0; i < beat_cyc.size(); i++) chk("lat2_beat_cyc", 64'(beat_cyc[i]), 64'(4 + i));
      chk("lat2_done_cyc", 64'(done_cyc), 64'd20);
      chk("lat2_credit",   64'(credit_viol), 64'd0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
